// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment digit scanner.
package seg_pkg;
   localparam int unsigned DIGITS   = 8;
   localparam int unsigned NIBBLE_W = 4;
   localparam int unsigned AN_LAT   = 2;
   localparam int unsigned IDX_W    = $clog2(DIGITS);

   typedef logic [IDX_W-1:0]           idx_t;
   typedef logic [DIGITS*NIBBLE_W-1:0] value_t;
   typedef logic [DIGITS-1:0]          en_t;

   function automatic en_t onehot(input idx_t i);
      return en_t'(1) << i;
   endfunction
endpackage

// File: rtl/seg_tick_div.sv
// Free-running divider: counts 0..DIV-1 and flags the last count of each slot.
module seg_tick_div #(
   parameter int unsigned DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   assign tick_o = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tick_o) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end
endmodule

// File: rtl/seg_scan.sv
// Eight-digit display scanner with frame-synchronous (tear-free) value updates
// and an anode pipeline aligned to a one-cycle downstream segment decoder.
module seg_scan
   import seg_pkg::*;
#(
   parameter int unsigned DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [31:0] value_i,
   input  logic [7:0]  en_i,
   output logic [3:0]  bin_o,
   output logic [7:0]  an_o,
   output logic        frame_o
);
   logic   tick;
   logic   wrap;
   idx_t   idx;
   logic   pend;
   value_t pend_val;
   en_t    pend_en;
   value_t act_val;
   en_t    act_en;
   en_t    an_pipe [AN_LAT];

   seg_tick_div #(.DIV(DIV)) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (tick)
   );

   assign wrap = tick && (idx == idx_t'(DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         frame_o <= 1'b0;
      end else begin
         if (tick) begin
            idx <= idx + idx_t'(1);
         end
         frame_o <= wrap;
      end
   end

   // A load landing on the wrap cycle bypasses pending so it shows this frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= 1'b0;
         pend_val <= '0;
         pend_en  <= '0;
         act_val  <= '0;
         act_en   <= '0;
      end else if (load_i && wrap) begin
         act_val <= value_i;
         act_en  <= en_i;
         pend    <= 1'b0;
      end else if (load_i) begin
         pend_val <= value_i;
         pend_en  <= en_i;
         pend     <= 1'b1;
      end else if (wrap && pend) begin
         act_val <= pend_val;
         act_en  <= pend_en;
         pend    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_o <= '0;
         for (int unsigned k = 0; k < AN_LAT; k++) begin
            an_pipe[k] <= '0;
         end
      end else begin
         bin_o      <= act_val[idx*NIBBLE_W +: NIBBLE_W];
         an_pipe[0] <= onehot(idx) & act_en;
         for (int unsigned k = 1; k < AN_LAT; k++) begin
            an_pipe[k] <= an_pipe[k-1];
         end
      end
   end

   assign an_o = an_pipe[AN_LAT-1];
endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan at DIV=4: 4-cycle slots, 32-cycle frames.
module tb_seg_scan;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_i = 1'b0;
   logic [31:0] value_i = '0;
   logic [7:0]  en_i = '0;
   logic [3:0]  bin_o;
   logic [7:0]  an_o;
   logic        frame_o;

   int n_checks = 0;
   int n_err    = 0;

   seg_scan #(.DIV(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_i),
      .value_i (value_i),
      .en_i    (en_i),
      .bin_o   (bin_o),
      .an_o    (an_o),
      .frame_o (frame_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Assert load_i during cycle F+at_j, where F is the frame cycle the caller is in.
   task automatic pulse_load(input int at_j, input logic [31:0] v, input logic [7:0] e);
      repeat (at_j) @(negedge clk);
      load_i  = 1'b1;
      value_i = v;
      en_i    = e;
      @(negedge clk);
      load_i  = 1'b0;
   endtask

   // Starts in a frame_o cycle F; checks F+1..F+32 against the expected active value.
   task automatic scan(input logic [31:0] v, input logic [7:0] e);
      int slot;
      logic [7:0] exp_an;
      check("frame_start", 32'(frame_o), 32'd1);
      for (int j = 1; j <= 32; j++) begin
         @(negedge clk);
         slot = (j - 1) / 4;
         check("bin", 32'(bin_o), (v >> (4 * slot)) & 32'hF);
         if (j >= 2) begin
            slot   = (j - 2) / 4;
            exp_an = e[slot] ? (8'b1 << slot) : 8'h00;
            check("an", 32'(an_o), 32'(exp_an));
         end
         check("frame", 32'(frame_o), (j == 32) ? 32'd1 : 32'd0);
      end
   endtask

   // Counts negedges from reset release until frame_o, bounded at 100.
   task automatic first_frame(input string tag);
      int n;
      logic dark;
      n    = 0;
      dark = 1'b1;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (an_o != 8'h00) dark = 1'b0;
         if (frame_o) break;
      end
      check(tag, 32'(n), 32'd32);
      check({tag, "_dark"}, 32'(dark), 32'd1);
   endtask

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_bin", 32'(bin_o), 32'd0);
      check("rst_an", 32'(an_o), 32'd0);
      check("rst_frame", 32'(frame_o), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      first_frame("first_frame");

      // Frame after reset stays dark while the first load is pending.
      fork
         pulse_load(2, 32'h87654321, 8'hFF);
         scan(32'h0, 8'h00);
      join

      fork
         scan(32'h87654321, 8'hFF);
         pulse_load(5, 32'h11111111, 8'hFF);
         begin
            repeat (20) @(negedge clk);
            pulse_load(0, 32'h22222222, 8'hFF);
         end
      join

      // Load in the wrap cycle (F+31) goes straight to the next frame.
      fork
         scan(32'h22222222, 8'hFF);
         pulse_load(31, 32'hAAAAAAAA, 8'hFF);
      join

      fork
         scan(32'hAAAAAAAA, 8'hFF);
         pulse_load(10, 32'h76543210, 8'h05);
      join

      scan(32'h76543210, 8'h05);

      // Mid-frame reset with a load pending.
      pulse_load(3, 32'h99999999, 8'hFF);
      repeat (6) @(negedge clk);
      check("pre_rst_bin", 32'(bin_o), 32'd2);
      check("pre_rst_an", 32'(an_o), 32'h04);
      #2 rst_n = 1'b0;
      #1;
      check("async_bin", 32'(bin_o), 32'd0);
      check("async_an", 32'(an_o), 32'd0);
      check("async_frame", 32'(frame_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first_frame("re_frame");
      scan(32'h0, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIV, default 100000, meaning: clk cycles per digit slot (100 MHz yields 1 kHz per digit); legal range 4..2^20.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 load_i  input  1  single-cycle strobe to capture value_i and en_i.
REQ-005 value_i  input  32  eight 4-bit digit codes; digit k is value_i[4k+3:4k].
REQ-006 en_i  input  8  per-digit enable; bit k lights digit k.
REQ-007 bin_o  output  4  registered digit code, feeds the downstream hex-to-segment stage (one-cycle registered decode).
REQ-008 an_o  output  8  one-hot digit select, active-high, aligned to the downstream segment output.
REQ-009 frame_o  output  1  one-cycle pulse at end of each 8-digit scan frame.

Function
REQ-010 Divider counter runs 0..DIV-1 and wraps to 0; tick asserted in the cycle count==DIV-1.
REQ-011 Digit index idx (3 bits) increments on tick and wraps 7->0.
REQ-012 Frame wrap is defined as tick with idx==7; frame_o SHALL be 1 in the cycle after the frame wrap, else 0.
REQ-013 load_i==1 captures value_i/en_i into pending registers and sets pend flag; a later load before the frame wrap overwrites pending (last wins).
REQ-014 At frame wrap with pend==1: active registers take pending; pend clears.
REQ-015 load_i coinciding with frame wrap: value_i/en_i go directly to active; pend clears.
REQ-016 Active value never changes mid-frame (no tearing).
REQ-017 bin_o <= active nibble selected by idx, every cycle (1-cycle latency from idx).
REQ-018 an_o is a 2-stage delayed copy of onehot(idx) AND active_en[idx], matching bin_o plus downstream register latency.
REQ-019 Disabled digit: an_o bit stays 0; bin_o still driven with the nibble.
REQ-020 At most one an_o bit high in any cycle.

Reset
REQ-021 rst_n low asynchronously clears divider count, idx, pend, pending and active value/enable, both an_o pipeline stages, bin_o=0, an_o=0, frame_o=0.
REQ-022 Reset mid-frame discards pending data.
REQ-023 After rst_n rises, the first tick occurs DIV cycles later.
REQ-024 After release, all digits stay dark until the first load is committed.

Structure
REQ-025 Shared package seg_pkg holds DIGITS=8, NIBBLE_W=4 and AN_LAT=2.
REQ-026 Sub-module seg_tick_div (parameter DIV; ports clk, rst_n, tick_o) implements REQ-010.
REQ-027 Remainder is flat: idx counter, load/commit registers and output pipeline.
REQ-028 Target size is 120-400 lines RTL.

Verification (DIV=4)
REQ-029 Reset, then load value 0x87654321 and en 0xFF -> after the next frame wrap, slots idx 0..7 give bin_o 1..8 and an_o 0x01,0x02,...,0x80; each slot lasts 4 cycles; an_o lags bin_o by 1 cycle.
REQ-030 Load 0x11111111 mid-frame, then 0x22222222 before the wrap -> the current frame still shows the old value; the next frame shows all 2s.
REQ-031 load_i in the exact frame-wrap cycle with 0xAAAAAAAA -> the new frame's digit 0 shows bin_o=0xA with no extra frame of delay.
REQ-032 en_i=0x05 -> only an_o 0x01 and 0x04 ever assert; frame_o pulses once every 32 cycles.
REQ-033 Assert rst_n low mid-frame with a load pending -> outputs are 0 immediately (asynchronous); after release, an_o stays 0 until a new load is committed.
